// File: rtl/boot_pkg.sv
// Shared constants for the SPI boot loader.
// Header length and the default boot window live here.
package boot_pkg;

    localparam int          HEADER_BYTES   = 3;
    localparam int          DEF_ADDR_W     = 18;
    localparam int unsigned DEF_BOOT_START = 32'h0000_C000;
    localparam int unsigned DEF_BOOT_END   = 32'h0000_FFFF;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO holding {address, data} write entries.
// Pushes while full and pops while empty are ignored.
module byte_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = store[rp[AW-1:0]];

    // Read/write pointers; the extra MSB separates full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wp[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/spi_boot_loader.sv
// Receives an SPI image (MSB first) and writes it into SRAM via req/ack.
// Holds the CPU in reset through busy until a frame is fully committed.
module spi_boot_loader
    import boot_pkg::*;
#(
    parameter int          ADDR_W          = DEF_ADDR_W,
    parameter int unsigned BOOT_START_ADDR = DEF_BOOT_START,
    parameter int unsigned BOOT_END_ADDR   = DEF_BOOT_END,
    parameter bit          HEADER_EN       = 1'b0,
    parameter bit          SAMPLE_FALL     = 1'b0,
    parameter int          FIFO_DEPTH      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_ss,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic              range_err
);

    localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(BOOT_START_ADDR);
    localparam logic [ADDR_W-1:0] END_A    = ADDR_W'(BOOT_END_ADDR);
    localparam logic [1:0]        HDR_DONE = 2'(HEADER_BYTES);
    localparam logic [1:0]        HDR_LAST = 2'(HEADER_BYTES - 1);
    localparam int                ENT_W    = ADDR_W + 8;

    // Synchronisers and edge-detect history
    logic ss_s1, ss_s2, ss_s3;
    logic sclk_s1, sclk_s2, sclk_s3;
    logic mosi_s1, mosi_s2;

    logic ss_fall, ss_rise;
    logic sclk_rise, sclk_fall;
    logic sample;

    // Byte assembly
    logic [6:0] shreg;
    logic [2:0] bit_cnt;
    logic       byte_vld;
    logic [7:0] byte_val;

    // Header / write pointer
    logic [1:0]        hdr_cnt;
    logic [ADDR_W-9:0] hdr_addr;
    logic [ADDR_W-1:0] wptr;
    logic              started;

    // Push decision
    logic is_hdr;
    logic is_data;
    logic out_of_range;
    logic push;
    logic pop;
    logic seen_data;

    // FIFO side
    logic [ENT_W-1:0] head;
    logic             full;
    logic             empty;

    // Bring the asynchronous SPI pins into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
            ss_s3   <= 1'b1;
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            ss_s1   <= spi_ss;
            ss_s2   <= ss_s1;
            ss_s3   <= ss_s2;
            sclk_s1 <= spi_sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign ss_fall   = ss_s3 & ~ss_s2;
    assign ss_rise   = ~ss_s3 & ss_s2;
    assign sclk_rise = ~sclk_s3 & sclk_s2;
    assign sclk_fall = sclk_s3 & ~sclk_s2;
    assign sample    = (SAMPLE_FALL ? sclk_fall : sclk_rise) & ~ss_s2;

    // Shift in mosi; flag a completed byte one cycle after its 8th edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_vld <= 1'b0;
            byte_val <= '0;
        end else begin
            byte_vld <= 1'b0;
            if (ss_fall || ss_rise) begin
                bit_cnt <= '0;
            end else if (sample) begin
                shreg   <= {shreg[5:0], mosi_s2};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_vld <= 1'b1;
                    byte_val <= {shreg, mosi_s2};
                end
            end
        end
    end

    assign is_hdr       = HEADER_EN && (hdr_cnt != HDR_DONE);
    assign is_data      = byte_vld && !is_hdr;
    assign out_of_range = !HEADER_EN && (wptr > END_A);
    assign push         = is_data && !out_of_range && !full;
    assign pop          = mem_ack && !empty;

    // Header collection and write-pointer maintenance.
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_cnt  <= '0;
            hdr_addr <= '0;
            wptr     <= START_A;
            started  <= 1'b0;
        end else if (ss_fall) begin
            hdr_cnt <= '0;
            started <= 1'b1;
            if (!HEADER_EN && !started) begin
                wptr <= START_A;
            end
        end else if (byte_vld) begin
            if (is_hdr) begin
                hdr_addr <= (ADDR_W-8)'({hdr_addr, byte_val});
                hdr_cnt  <= hdr_cnt + 2'd1;
                if (hdr_cnt == HDR_LAST) begin
                    wptr <= {hdr_addr, byte_val};
                end
            end else if (!out_of_range) begin
                // Dropped-on-full bytes still advance the pointer.
                wptr <= wptr + ADDR_W'(1);
            end
        end
    end

    // Sticky status flags and load completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun   <= 1'b0;
            range_err <= 1'b0;
            seen_data <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (is_data && out_of_range) begin
                range_err <= 1'b1;
            end
            if (is_data && !out_of_range && full) begin
                overrun <= 1'b1;
            end
            if (push) begin
                seen_data <= 1'b1;
            end
            if (seen_data && ss_s2 && empty && !byte_vld) begin
                done <= 1'b1;
            end
        end
    end

    byte_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({wptr, byte_val}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // The FIFO head is presented directly, so it is stable until popped.
    assign mem_req  = ~empty;
    assign mem_addr = empty ? START_A : head[ENT_W-1:8];
    assign mem_data = empty ? 8'h00 : head[7:0];
    assign busy     = ~done;

endmodule
